// File: rtl/xgmii32_rx_link_fault.sv
// -----------------------------------------------------------------------------
// xgmii32_rx_link_fault
//
// Reconciliation-sublayer link-fault monitor. It watches the 32-bit XGMII
// receive stream coming out of pcs_rx_32b (pma_rx_clk domain). It counts local
// and remote fault sequence ordered sets, resolves the link status
// (LOCAL / REMOTE / OK), and tells the transmit side what it must send.
//
// Ports:
//   clk           pma_rx_clk domain clock
//   rst           asynchronous, active-low reset
//   xgmii_rx      {ena[36], ctrl[35:32], data[31:0]}; a word counts only when ena=1
//   pma_sync      block lock from pcs_rx_32b; low forces LOCAL status
//   local_fault   status is LOCAL
//   remote_fault  status is REMOTE
//   link_ok       status is OK
//   tx_fault_req  00 normal, 01 send remote-fault sequences, 10 send idle
//   fault_cnt     saturating count of OK -> fault transitions
// -----------------------------------------------------------------------------
module xgmii32_rx_link_fault #(
  parameter int SEQ_THRESH = 4,
  parameter int COL_WINDOW = 256,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [36:0]      xgmii_rx,
  input  logic             pma_sync,
  output logic             local_fault,
  output logic             remote_fault,
  output logic             link_ok,
  output logic [1:0]       tx_fault_req,
  output logic [CNT_W-1:0] fault_cnt
);

  localparam int COL_W = $clog2(COL_WINDOW + 1);
  localparam int SEQ_W = $clog2(SEQ_THRESH + 1);

  localparam logic [COL_W-1:0] COL_LAST = COL_W'(COL_WINDOW);
  localparam logic [SEQ_W-1:0] SEQ_MAX  = SEQ_W'(SEQ_THRESH);
  localparam logic [SEQ_W-1:0] SEQ_ONE  = SEQ_W'(1);

  typedef enum logic [1:0] {
    ST_OK     = 2'd0,
    ST_LOCAL  = 2'd1,
    ST_REMOTE = 2'd2
  } status_e;

  typedef enum logic [1:0] {
    FT_NONE   = 2'd0,
    FT_LOCAL  = 2'd1,
    FT_REMOTE = 2'd2
  } ftype_e;

  // Sequence counter saturates at the threshold, so repeated fault words keep
  // the declared status without wrapping.
  function automatic logic [SEQ_W-1:0] seq_inc_sat(input logic [SEQ_W-1:0] v);
    return (v >= SEQ_MAX) ? SEQ_MAX : v + 1'b1;
  endfunction

  function automatic logic [CNT_W-1:0] cnt_inc_sat(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  logic        rx_ena;
  logic [3:0]  rx_ctrl;
  logic [31:0] rx_data;
  ftype_e      word_type;

  assign rx_ena  = xgmii_rx[36];
  assign rx_ctrl = xgmii_rx[35:32];
  assign rx_data = xgmii_rx[31:0];

  // Only lane 0 is examined; a sequence ordered set that sat in 64-bit lane 4
  // shows up as lane 0 of the following 32-bit word.
  always_comb begin
    word_type = FT_NONE;
    if (rx_ctrl == 4'b0001 && rx_data[23:0] == 24'h00009C) begin
      case (rx_data[31:24])
        8'h01:   word_type = FT_LOCAL;
        8'h02:   word_type = FT_REMOTE;
        default: word_type = FT_NONE;
      endcase
    end
  end

  status_e          status_p0,    status_nxt;
  ftype_e           last_type_p0, last_type_nxt;
  logic [SEQ_W-1:0] seq_cnt_p0,   seq_cnt_nxt;
  logic [COL_W-1:0] col_cnt_p0,   col_cnt_nxt;
  logic [COL_W-1:0] col_inc;
  logic             fault_evt_p0, fault_evt_nxt;

  assign col_inc = col_cnt_p0 + 1'b1;

  // ---- stage p0: fault-sequence counting and status resolution ----
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      status_p0    <= ST_LOCAL;
      last_type_p0 <= FT_NONE;
      seq_cnt_p0   <= '0;
      col_cnt_p0   <= '0;
      fault_evt_p0 <= 1'b0;
    end else begin
      status_p0    <= status_nxt;
      last_type_p0 <= last_type_nxt;
      seq_cnt_p0   <= seq_cnt_nxt;
      col_cnt_p0   <= col_cnt_nxt;
      fault_evt_p0 <= fault_evt_nxt;
    end
  end

  always_comb begin
    status_nxt    = status_p0;
    last_type_nxt = last_type_p0;
    seq_cnt_nxt   = seq_cnt_p0;
    col_cnt_nxt   = col_cnt_p0;
    if (!pma_sync) begin
      status_nxt    = ST_LOCAL;
      last_type_nxt = FT_NONE;
      seq_cnt_nxt   = '0;
      col_cnt_nxt   = '0;
    end else if (rx_ena) begin
      if (word_type != FT_NONE) begin
        col_cnt_nxt = '0;
        if (word_type == last_type_p0) begin
          seq_cnt_nxt = seq_inc_sat(seq_cnt_p0);
        end else begin
          last_type_nxt = word_type;
          seq_cnt_nxt   = SEQ_ONE;
        end
        if (seq_cnt_nxt == SEQ_MAX) begin
          status_nxt = (word_type == FT_LOCAL) ? ST_LOCAL : ST_REMOTE;
        end
      end else if (col_inc == COL_LAST) begin
        // A full clean window clears any partial sequence; if already OK
        // this simply keeps it OK.
        status_nxt    = ST_OK;
        last_type_nxt = FT_NONE;
        seq_cnt_nxt   = '0;
        col_cnt_nxt   = '0;
      end else begin
        col_cnt_nxt = col_inc;
      end
    end
  end

  // LOCAL<->REMOTE moves are not fault events; only leaving OK is.
  assign fault_evt_nxt = (status_p0 == ST_OK) && (status_nxt != ST_OK);

  logic       local_fault_d, remote_fault_d, link_ok_d;
  logic [1:0] tx_fault_req_d;

  always_comb begin
    local_fault_d  = 1'b0;
    remote_fault_d = 1'b0;
    link_ok_d      = 1'b0;
    tx_fault_req_d = 2'b00;
    case (status_p0)
      ST_LOCAL: begin
        local_fault_d  = 1'b1;
        tx_fault_req_d = 2'b01;
      end
      ST_REMOTE: begin
        remote_fault_d = 1'b1;
        tx_fault_req_d = 2'b10;
      end
      default: begin
        link_ok_d      = 1'b1;
        tx_fault_req_d = 2'b00;
      end
    endcase
  end

  // ---- stage p1: registered status decode and fault event counter ----
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      local_fault  <= 1'b1;
      remote_fault <= 1'b0;
      link_ok      <= 1'b0;
      tx_fault_req <= 2'b01;
      fault_cnt    <= '0;
    end else begin
      local_fault  <= local_fault_d;
      remote_fault <= remote_fault_d;
      link_ok      <= link_ok_d;
      tx_fault_req <= tx_fault_req_d;
      if (fault_evt_p0) begin
        fault_cnt <= cnt_inc_sat(fault_cnt);
      end
    end
  end

endmodule

// File: tb/tb_xgmii32_rx_link_fault.sv
// -----------------------------------------------------------------------------
// tb_xgmii32_rx_link_fault
//
// Directed bench for xgmii32_rx_link_fault. Two instances share one stimulus
// stream: the default build (CNT_W=16) and a CNT_W=2 build for the counter
// saturation case. A word-level model predicts status and fault count from
// the fault-sequence rules, and every falling edge compares both DUTs with it.
// Literal expectations at key points pin the model as well.
// -----------------------------------------------------------------------------
module tb_xgmii32_rx_link_fault;

  localparam int SEQ_THRESH = 4;
  localparam int COL_WINDOW = 256;

  localparam logic [31:0] IDLE_D = 32'h07070707;
  localparam logic [31:0] LF_D   = 32'h0100009C;
  localparam logic [31:0] RF_D   = 32'h0200009C;
  localparam logic [31:0] BAD_D  = 32'h0300009C;

  logic        clk = 1'b0;
  logic        rst;
  logic [36:0] xgmii_rx;
  logic        pma_sync;

  logic        local_fault, remote_fault, link_ok;
  logic [1:0]  tx_fault_req;
  logic [15:0] fault_cnt;

  logic        local_fault2, remote_fault2, link_ok2;
  logic [1:0]  tx_fault_req2;
  logic [1:0]  fault_cnt2;

  always #5 clk = ~clk;

  xgmii32_rx_link_fault #(.SEQ_THRESH(SEQ_THRESH), .COL_WINDOW(COL_WINDOW), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .xgmii_rx(xgmii_rx), .pma_sync(pma_sync),
    .local_fault(local_fault), .remote_fault(remote_fault), .link_ok(link_ok),
    .tx_fault_req(tx_fault_req), .fault_cnt(fault_cnt)
  );

  xgmii32_rx_link_fault #(.SEQ_THRESH(SEQ_THRESH), .COL_WINDOW(COL_WINDOW), .CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst), .xgmii_rx(xgmii_rx), .pma_sync(pma_sync),
    .local_fault(local_fault2), .remote_fault(remote_fault2), .link_ok(link_ok2),
    .tx_fault_req(tx_fault_req2), .fault_cnt(fault_cnt2)
  );

  int n_total = 0;
  int n_pass  = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s at %0t: got %0h, expected %0h", nm, $time, act, exp);
  endtask

  // ---------------------------------------------------------------------------
  // Model. Status: 0 = OK, 1 = LOCAL, 2 = REMOTE. m_* is the state after the
  // latest sampled word; e_* is what the outputs must show now (one edge later).
  // ---------------------------------------------------------------------------
  int m_st    = 1;
  int m_clean = 0;  // valid non-fault words since last fault word / sync loss
  int m_run   = 0;  // length of the current same-type fault run
  int m_type  = 0;
  int m_cnt   = 0;
  int e_st    = 1;
  int e_cnt   = 0;

  task automatic model_reset();
    m_st = 1; m_clean = 0; m_run = 0; m_type = 0; m_cnt = 0;
    e_st = 1; e_cnt = 0;
  endtask

  task automatic model_step();
    int t;
    int prev;
    e_st = m_st;
    e_cnt = m_cnt;
    prev = m_st;
    t = 0;
    if (xgmii_rx[35:32] == 4'h1 && xgmii_rx[23:0] == 24'h00009C &&
        (xgmii_rx[31:24] == 8'h01 || xgmii_rx[31:24] == 8'h02))
      t = int'(xgmii_rx[31:24]);
    if (!pma_sync) begin
      m_st = 1; m_clean = 0; m_run = 0; m_type = 0;
    end else if (xgmii_rx[36]) begin
      if (t != 0) begin
        m_clean = 0;
        if (t == m_type) m_run++;
        else begin
          m_type = t;
          m_run = 1;
        end
        if (m_run >= SEQ_THRESH) m_st = t;
      end else begin
        m_clean++;
        if (m_clean == COL_WINDOW) begin
          m_st = 0; m_run = 0; m_type = 0;
        end
      end
    end
    if (prev == 0 && m_st != 0) m_cnt++;
  endtask

  always @(posedge clk or negedge rst) begin
    if (!rst) model_reset();
    else model_step();
  end

  always @(negedge clk) begin
    chk("local_fault",   local_fault,   e_st == 1);
    chk("remote_fault",  remote_fault,  e_st == 2);
    chk("link_ok",       link_ok,       e_st == 0);
    chk("tx_fault_req",  tx_fault_req,  (e_st == 1) ? 1 : (e_st == 2) ? 2 : 0);
    chk("fault_cnt",     fault_cnt,     e_cnt);
    chk("local_fault2",  local_fault2,  e_st == 1);
    chk("remote_fault2", remote_fault2, e_st == 2);
    chk("link_ok2",      link_ok2,      e_st == 0);
    chk("tx_fault_req2", tx_fault_req2, (e_st == 1) ? 1 : (e_st == 2) ? 2 : 0);
    chk("fault_cnt2",    fault_cnt2,    (e_cnt > 3) ? 3 : e_cnt);
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers: each call presents one word for exactly one rising edge
  // and returns 1 time unit after that edge.
  // ---------------------------------------------------------------------------
  task automatic send(input logic e, input logic [3:0] c, input logic [31:0] d);
    xgmii_rx = {e, c, d};
    @(posedge clk);
    #1;
  endtask

  task automatic idles(input int n);
    for (int i = 0; i < n; i++) send(1'b1, 4'hF, IDLE_D);
  endtask

  task automatic nop();
    send(1'b0, 4'hF, IDLE_D);
  endtask

  task automatic lf_word();
    send(1'b1, 4'h1, LF_D);
  endtask

  task automatic rf_word();
    send(1'b1, 4'h1, RF_D);
  endtask

  task automatic sync_drop();
    pma_sync = 1'b0;
    idles(1);
    pma_sync = 1'b1;
  endtask

  initial begin
    rst      = 1'b0;
    pma_sync = 1'b0;
    xgmii_rx = {1'b0, 4'hF, IDLE_D};
    repeat (3) @(posedge clk);
    #1;
    chk("rst_local_fault",  local_fault,  1);
    chk("rst_link_ok",      link_ok,      0);
    chk("rst_tx_fault_req", tx_fault_req, 2'b01);
    chk("rst_fault_cnt",    fault_cnt,    0);
    rst      = 1'b1;
    pma_sync = 1'b1;

    // Link-up: 255 clean words (one a non-fault sequence code) are not enough.
    idles(100);
    send(1'b1, 4'h1, BAD_D);
    idles(154);
    nop();
    chk("s1_not_ok_255", link_ok, 0);
    idles(1);
    chk("s1_latency", link_ok, 0);
    nop();
    chk("s1_link_ok",     link_ok,      1);
    chk("s1_tx_req",      tx_fault_req, 2'b00);
    chk("s1_fault_cnt",   fault_cnt,    0);

    // Four local-fault words with 20-idle gaps.
    for (int i = 0; i < 4; i++) begin
      if (i > 0) idles(20);
      if (i == 3) begin
        nop();
        chk("s2_ok_after_3", link_ok, 1);
      end
      lf_word();
    end
    nop();
    chk("s2_local_fault", local_fault,  1);
    chk("s2_tx_req",      tx_fault_req, 2'b01);
    chk("s2_fault_cnt",   fault_cnt,    1);

    // LOCAL -> REMOTE directly, not counted.
    for (int i = 0; i < 4; i++) begin
      idles(20);
      rf_word();
    end
    nop();
    chk("s2_remote_fault", remote_fault, 1);
    chk("s2_cnt_hold",     fault_cnt,    1);
    idles(COL_WINDOW);
    nop();
    chk("s2_recover", link_ok, 1);

    // Partial remote runs separated by a full clean window do not accumulate.
    for (int i = 0; i < 3; i++) begin idles(20); rf_word(); end
    idles(300);
    for (int i = 0; i < 3; i++) begin idles(20); rf_word(); end
    nop();
    chk("s3_still_ok", link_ok, 1);
    idles(20);
    rf_word();
    nop();
    chk("s3_remote_fault", remote_fault, 1);
    chk("s3_tx_req",       tx_fault_req, 2'b10);
    chk("s3_fault_cnt",    fault_cnt,    2);
    idles(COL_WINDOW);

    // Alternating types never build a run.
    for (int i = 0; i < 10; i++) begin
      idles(5); lf_word();
      idles(5); rf_word();
    end
    nop();
    chk("s4_alt_ok", link_ok, 1);

    // Sync loss while OK, twice; the CNT_W=2 build saturates at 3.
    sync_drop();
    nop();
    chk("s6_local_fault", local_fault, 1);
    chk("s6_fault_cnt",   fault_cnt,   3);
    chk("s6_cnt2_at_3",   fault_cnt2,  3);
    idles(COL_WINDOW);
    sync_drop();
    nop();
    chk("s6_fault_cnt_4", fault_cnt,  4);
    chk("s6_cnt2_sat",    fault_cnt2, 3);

    // Recovery with ena=0 between every valid word: timing in valid words.
    for (int i = 0; i < COL_WINDOW - 1; i++) begin nop(); idles(1); end
    nop();
    chk("s5_not_ok_255", link_ok, 0);
    idles(1);
    nop();
    chk("s5_link_ok", link_ok, 1);

    // Asynchronous reset in the middle of a clean run.
    idles(100);
    rst = 1'b0;
    #1;
    chk("arst_local_fault", local_fault, 1);
    chk("arst_fault_cnt",   fault_cnt,   0);
    @(posedge clk);
    #1;
    rst = 1'b1;

    // A fault word late in the window restarts the full clean-window count.
    idles(200);
    lf_word();
    idles(COL_WINDOW - 1);
    nop();
    chk("late_fault_hold", local_fault, 1);
    idles(1);
    nop();
    chk("late_fault_ok", link_ok, 1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
